// File: rtl/reg_alu_engine.sv
// Register-file ALU engine: accepts one command at a time, reads operands, executes,
// writes back, then holds the result until the consumer takes it.
module reg_alu_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 16,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             cmd_use_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [4:0]       flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StResp} state_e;

    state_e state_q, state_d;

    logic [3:0]       op_q;
    logic [AW-1:0]    dst_q, srca_q, srcb_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q;
    logic [4:0]       flags_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;
    logic             alu_wr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    assign cmd_ready = (state_q == StIdle) && reset;
    assign res_valid = (state_q == StResp);
    assign res_data  = res_q;
    assign flags     = flags_q;
    assign dbg_data  = regs[dbg_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            dst_q     <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (state_q == StIdle && cmd_valid) begin
            op_q      <= cmd_op;
            dst_q     <= cmd_dst;
            srca_q    <= cmd_srca;
            srcb_q    <= cmd_srcb;
            imm_q     <= cmd_imm;
            use_imm_q <= cmd_use_imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state_q == StRead) begin
            a_q <= regs[srca_q];
            b_q <= use_imm_q ? imm_q : regs[srcb_q];
        end
    end

    // Flag layout {C, L, F, Z, N}; ops that don't define C/L/F keep the old values.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = '0;
        alu_flags = flags_q;
        alu_wr    = 1'b1;
        case (op_q)
            4'd0: begin
                alu_res      = sum[WIDTH-1:0];
                alu_flags[4] = sum[WIDTH];
                alu_flags[3] = 1'b0;
                alu_flags[2] = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd1, 4'd8: begin
                alu_res      = diff[WIDTH-1:0];
                alu_flags[4] = diff[WIDTH];
                alu_flags[3] = diff[WIDTH];
                alu_flags[2] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (diff[WIDTH-1] != a_q[WIDTH-1]);
                alu_wr       = (op_q == 4'd1);
            end
            4'd2: alu_res = a_q & b_q;
            4'd3: alu_res = a_q | b_q;
            4'd4: alu_res = a_q ^ b_q;
            4'd5: alu_res = ~a_q;
            4'd6: alu_res = a_q << b_q[SW-1:0];
            4'd7: alu_res = a_q >> b_q[SW-1:0];
            4'd9: alu_res = b_q;
            default: alu_wr = 1'b0;
        endcase
        if (op_q <= 4'd9) begin
            alu_flags[1] = (alu_res == '0);
            alu_flags[0] = alu_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (state_q == StExec) begin
            res_q   <= alu_res;
            flags_q <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (state_q == StExec && alu_wr) begin
            regs[dst_q] <= alu_res;
        end
    end

endmodule

// File: tb/tb_reg_alu_engine.sv
// Self-checking bench for reg_alu_engine: directed scenarios plus randomized commands
// checked against an arithmetic reference model.
module tb_reg_alu_engine;

    localparam int W  = 16;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [AW-1:0] cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
    logic [W-1:0]  cmd_imm = '0;
    logic          cmd_use_imm = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [W-1:0]  res_data;
    logic [4:0]    flags;
    logic [AW-1:0] dbg_addr = '0;
    logic [W-1:0]  dbg_data;

    reg_alu_engine #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         mregs [NR];
    logic [4:0] mflags;
    logic [31:0] obs_res, obs_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s > M / 2 - 1) || (s < -(M / 2));
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model_exec(input int op, input int a, input int b,
                              output int res, output bit wr);
        int s;
        res = 0;
        wr  = (op <= 7) || (op == 9);
        case (op)
            0: begin
                s = a + b;
                res = s % M;
                mflags[4] = (s >= M);
                mflags[3] = 1'b0;
                mflags[2] = out_of_range(to_signed(a) + to_signed(b));
            end
            1, 8: begin
                res = (a - b + M) % M;
                mflags[4] = (a < b);
                mflags[3] = (a < b);
                mflags[2] = out_of_range(to_signed(a) - to_signed(b));
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (M - 1) - a;
            6: res = (a << (b % W)) % M;
            7: res = a >> (b % W);
            9: res = b;
            default: res = 0;
        endcase
        if (op <= 9) begin
            mflags[1] = (res == 0);
            mflags[0] = (res >= M / 2);
        end
    endtask

    task automatic do_cmd(input int op, input int dst, input int sa, input int sb,
                          input int imm, input bit use_imm, input int hold);
        int a, b, eres;
        bit wr;
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        cmd_op = op[3:0]; cmd_dst = dst[AW-1:0]; cmd_srca = sa[AW-1:0];
        cmd_srcb = sb[AW-1:0]; cmd_imm = imm[W-1:0]; cmd_use_imm = use_imm;
        cmd_valid = 1'b1;
        res_ready = (hold == 0);
        a = mregs[sa];
        b = use_imm ? imm : mregs[sb];
        model_exec(op, a, b, eres, wr);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("lat_read_valid", res_valid, 0);
        check("busy_ready", cmd_ready, 0);
        @(negedge clk);
        check("lat_exec_valid", res_valid, 0);
        @(negedge clk);
        check("resp_valid", res_valid, 1);
        check("res_data", res_data, eres);
        check("flags", flags, mflags);
        obs_res = res_data;
        obs_flags = flags;
        if (hold > 0) begin
            // Command offered while busy must be dropped.
            cmd_op = 4'd9; cmd_use_imm = 1'b1; cmd_imm = ~eres[W-1:0]; cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, eres);
            check("hold_flags", flags, mflags);
            check("hold_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("done_valid", res_valid, 0);
        check("done_ready", cmd_ready, 1);
        if (wr) mregs[dst] = eres;
        dbg_addr = dst[AW-1:0];
        #1 check("dbg_dst", dbg_data, mregs[dst]);
    endtask

    initial begin
        int v;
        for (int i = 0; i < NR; i++) mregs[i] = 0;
        mflags = '0;
        #2;
        check("rst_valid", res_valid, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_data", res_data, 0);
        check("rst_flags", flags, 0);
        check("rst_dbg", dbg_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // a: MOV immediate
        do_cmd(9, 3, 0, 0, 'h1234, 1, 0);
        check("a_res", obs_res, 'h1234);
        check("a_zn", obs_flags[1:0], 2'b00);
        dbg_addr = 3;
        #1 check("a_dbg", dbg_data, 'h1234);

        // b: signed overflow on ADD
        do_cmd(9, 1, 0, 0, 'h7FFF, 1, 0);
        do_cmd(9, 2, 0, 0, 'h0001, 1, 0);
        do_cmd(0, 4, 1, 2, 0, 0, 0);
        check("b_res", obs_res, 'h8000);
        check("b_flags", obs_flags, 5'b00101);

        // c: borrow, then logic op keeps C/L/F
        do_cmd(9, 7, 0, 0, 0, 1, 0);
        do_cmd(9, 8, 0, 0, 1, 1, 0);
        do_cmd(1, 9, 7, 8, 0, 0, 0);
        check("c_sub_res", obs_res, 'hFFFF);
        check("c_sub_flags", obs_flags, 5'b11001);
        do_cmd(9, 10, 0, 0, 'h00FF, 1, 0);
        do_cmd(9, 11, 0, 0, 'hFF00, 1, 0);
        do_cmd(2, 12, 10, 11, 0, 0, 0);
        check("c_and_res", obs_res, 0);
        check("c_and_flags", obs_flags, 5'b11010);

        // d: CMP does not write; shift amount uses low bits only
        do_cmd(9, 5, 0, 0, 5, 1, 0);
        do_cmd(9, 6, 0, 0, 5, 1, 0);
        do_cmd(8, 5, 5, 6, 0, 0, 0);
        check("d_cmp_flags", obs_flags, 5'b00010);
        dbg_addr = 5;
        #1 check("d_cmp_nowrite", dbg_data, 5);
        do_cmd(6, 13, 2, 0, 'h0013, 1, 0);
        check("d_lsh_res", obs_res, 'h0008);

        // e: backpressure with an ignored command pulse
        do_cmd(4, 3, 3, 1, 0, 0, 5);

        // f: reset during EXEC aborts the write
        @(negedge clk);
        cmd_op = 4'd0; cmd_dst = 14; cmd_srca = 1; cmd_srcb = 2; cmd_use_imm = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = 0;
        mflags = '0;
        dbg_addr = 1;
        #1;
        check("f_valid", res_valid, 0);
        check("f_ready", cmd_ready, 0);
        check("f_data", res_data, 0);
        check("f_flags", flags, 0);
        check("f_dbg_r1", dbg_data, 0);
        @(negedge clk);
        reset = 1'b1;
        dbg_addr = 14;
        #1;
        check("f_dst_zero", dbg_data, 0);
        check("f_ready_after", cmd_ready, 1);
        do_cmd(9, 14, 0, 0, 'hBEEF, 1, 0);

        // Randomized traffic
        for (int r = 0; r < NR; r++) do_cmd(9, r, 0, 0, $urandom_range(0, M - 1), 1, 0);
        for (int n = 0; n < 150; n++) begin
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            do_cmd($urandom_range(0, 15), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                   $urandom_range(0, NR - 1), $urandom_range(0, M - 1),
                   1'($urandom_range(0, 1)), v);
        end
        for (int r = 0; r < NR; r++) begin
            dbg_addr = r[AW-1:0];
            #1 check("final_dbg", dbg_data, mregs[r]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
